ddr2_cmd_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single DDR2 controller command bus (cmd/sz/op/din/addr)

---
 rtl/ddr2_cmd_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_ddr2_cmd_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_cmd_arbiter.sv
// ddr2_cmd_arbiter: round-robin sharing of the DDR2 controller command bus.
// Requester i owns slice i of every packed request port. The controller's
// 'fetching' acts as ready: the bus value is taken on each edge where it is 1.
// Block writes are streamed beat by beat after the command is accepted.
// Each streamed beat spends one cycle being loaded from the requester. It is
// then offered to the controller until a fetching edge consumes it, so the bus
// never shows data that the requester has already been told to advance past.
// Optional build macro: DDR2_ARB_STATS_EN adds per-requester grant/drop counters
// that are read through stat_sel.
module ddr2_cmd_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_cmd,
    input  logic [2*NREQ-1:0] req_sz,
    input  logic [3*NREQ-1:0] req_op,
    input  logic [16*NREQ-1:0] req_din,
    input  logic [25*NREQ-1:0] req_addr,
    output logic [NREQ-1:0]   req_ack,
    output logic [NREQ-1:0]   req_data_ack,
    output logic [NREQ-1:0]   req_err,
    input  logic              fetching,
    output logic [2:0]        cmd,
    output logic [1:0]        sz,
    output logic [2:0]        op,
    output logic [15:0]       din,
    output logic [24:0]       addr,
    output logic              busy,
`ifdef DDR2_ARB_STATS_EN
    input  logic [2:0]        stat_sel,
    output logic [15:0]       stat_grants,
    output logic [15:0]       stat_drops,
`endif
    output logic [2:0]        grant_id
);

    localparam logic [2:0] CMD_BWR = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BURST} state_t;

    state_t      r_state;
    logic [2:0]  r_ptr, r_gid, r_beats;
    logic        r_din_vld, r_busy;
    logic [2:0]  r_cmd, r_op;
    logic [1:0]  r_sz;
    logic [15:0] r_din;
    logic [24:0] r_addr;
    logic [NREQ-1:0] r_req_ack, r_req_data_ack, r_req_err;

    // Requester slices, padded to 8 entries so a 3-bit index always fits.
    logic [2:0]  w_cmd_a  [8];
    logic [1:0]  w_sz_a   [8];
    logic [2:0]  w_op_a   [8];
    logic [15:0] w_din_a  [8];
    logic [24:0] w_addr_a [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
        if (gi < NREQ) begin : g_used
            assign w_cmd_a[gi]  = req_cmd[3*gi +: 3];
            assign w_sz_a[gi]   = req_sz[2*gi +: 2];
            assign w_op_a[gi]   = req_op[3*gi +: 3];
            assign w_din_a[gi]  = req_din[16*gi +: 16];
            assign w_addr_a[gi] = req_addr[25*gi +: 25];
        end else begin : g_pad
            assign w_cmd_a[gi]  = '0;
            assign w_sz_a[gi]   = '0;
            assign w_op_a[gi]   = '0;
            assign w_din_a[gi]  = '0;
            assign w_addr_a[gi] = '0;
        end
    end

    // A requester whose ack is visible this cycle is masked, so a requester
    // that drops valid one cycle late is not granted a second time.
    logic [7:0]      w_elig;
    logic            w_found;
    logic [2:0]      w_win;
    logic [2:0]      w_win_cmd;
    logic            w_illegal, w_drop, w_accept;
    logic [NREQ-1:0] w_win_oh, w_gid_oh;

    assign w_elig    = 8'(req_valid & ~r_req_ack);
    assign w_win_cmd = w_cmd_a[w_win];
    assign w_illegal = (w_win_cmd == 3'd0) || (w_win_cmd == 3'd7);
    assign w_drop    = (r_state == S_IDLE) && w_found && w_illegal;
    assign w_accept  = (r_state == S_ISSUE) && fetching;
    assign w_win_oh  = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    assign w_gid_oh  = {{(NREQ-1){1'b0}}, 1'b1} << r_gid;

    // Round-robin search: first eligible requester at or after the pointer.
    always_comb begin
        logic [3:0] sum;
        // NOTE: every variable written here gets a value before any branch,
        // otherwise the tool infers a latch to hold the old value.
        w_found = 1'b0;
        w_win   = '0;
        sum     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, r_ptr} + 4'(k);
            if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
            if (!w_found && w_elig[sum[2:0]]) begin
                w_found = 1'b1;
                w_win   = sum[2:0];
            end
        end
    end

    // Command FSM: arbitrate in IDLE, hold bus in ISSUE, stream beats in BURST.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_ptr          <= '0;
            r_gid          <= '0;
            r_beats        <= '0;
            r_din_vld      <= 1'b0;
            r_busy         <= 1'b0;
            r_cmd          <= '0;
            r_sz           <= '0;
            r_op           <= '0;
            r_din          <= '0;
            r_addr         <= '0;
            r_req_ack      <= '0;
            r_req_data_ack <= '0;
            r_req_err      <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples pre-edge values regardless of statement order.
            r_req_ack      <= '0;
            r_req_data_ack <= '0;
            r_req_err      <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_ptr <= (w_win == 3'(NREQ-1)) ? 3'd0 : w_win + 3'd1;
                        if (w_drop) begin
                            r_req_ack <= w_win_oh;
                            r_req_err <= w_win_oh;
                        end else begin
                            r_cmd   <= w_win_cmd;
                            r_sz    <= w_sz_a[w_win];
                            r_op    <= w_op_a[w_win];
                            r_din   <= w_din_a[w_win];
                            r_addr  <= w_addr_a[w_win];
                            r_gid   <= w_win;
                            r_beats <= {w_sz_a[w_win], 1'b1};   // 2*(sz+1)-1
                            r_busy  <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (fetching) begin
                        r_req_ack <= w_gid_oh;
                        r_cmd     <= '0;
                        if (r_cmd == CMD_BWR) begin
                            r_req_data_ack <= w_gid_oh;
                            r_beats        <= r_beats - 3'd1;
                            r_din_vld      <= 1'b0;
                            r_state        <= S_BURST;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_BURST: begin
                    if (!r_din_vld) begin
                        r_din     <= w_din_a[r_gid];
                        r_din_vld <= 1'b1;
                    end else if (fetching) begin
                        r_req_data_ack <= w_gid_oh;
                        r_din_vld      <= 1'b0;
                        if (r_beats == 3'd0) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_beats <= r_beats - 3'd1;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DDR2_ARB_STATS_EN
    logic [15:0] r_stat_grants [8];
    logic [15:0] r_stat_drops  [8];

    // Saturating per-requester counters of accepted and dropped commands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: this counter array is small and must read zero after
            // reset, so each entry is cleared explicitly.
            for (int i = 0; i < 8; i++) begin
                r_stat_grants[i] <= '0;
                r_stat_drops[i]  <= '0;
            end
        end else begin
            if (w_accept && r_stat_grants[r_gid] != 16'hFFFF)
                r_stat_grants[r_gid] <= r_stat_grants[r_gid] + 16'd1;
            if (w_drop && r_stat_drops[w_win] != 16'hFFFF)
                r_stat_drops[w_win] <= r_stat_drops[w_win] + 16'd1;
        end
    end

    assign stat_grants = r_stat_grants[stat_sel];
    assign stat_drops  = r_stat_drops[stat_sel];
`endif

    assign req_ack      = r_req_ack;
    assign req_data_ack = r_req_data_ack;
    assign req_err      = r_req_err;
    assign cmd          = r_cmd;
    assign sz           = r_sz;
    assign op           = r_op;
    assign din          = r_din;
    assign addr         = r_addr;
    assign busy         = r_busy;
    assign grant_id     = r_gid;

endmodule

// File: tb/tb_ddr2_cmd_arbiter.sv
// Directed testbench for ddr2_cmd_arbiter (NREQ=4).
// All expected values are hand-derived from the arbiter's documented behaviour.
module tb_ddr2_cmd_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [3*NREQ-1:0] req_cmd;
    logic [2*NREQ-1:0] req_sz;
    logic [3*NREQ-1:0] req_op;
    logic [16*NREQ-1:0] req_din;
    logic [25*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_ack, req_data_ack, req_err;
    logic              fetching;
    logic [2:0]        cmd, op, grant_id;
    logic [1:0]        sz;
    logic [15:0]       din;
    logic [24:0]       addr;
    logic              busy;
`ifdef DDR2_ARB_STATS_EN
    logic [2:0]        stat_sel;
    logic [15:0]       stat_grants, stat_drops;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ddr2_cmd_arbiter #(.NREQ(NREQ)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_cmd      (req_cmd),
        .req_sz       (req_sz),
        .req_op       (req_op),
        .req_din      (req_din),
        .req_addr     (req_addr),
        .req_ack      (req_ack),
        .req_data_ack (req_data_ack),
        .req_err      (req_err),
        .fetching     (fetching),
        .cmd          (cmd),
        .sz           (sz),
        .op           (op),
        .din          (din),
        .addr         (addr),
        .busy         (busy),
`ifdef DDR2_ARB_STATS_EN
        .stat_sel     (stat_sel),
        .stat_grants  (stat_grants),
        .stat_drops   (stat_drops),
`endif
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] c,
                           input logic [1:0] s, input logic [15:0] d, input logic [24:0] a);
        req_valid[i]          = v;
        req_cmd[3*i +: 3]     = c;
        req_sz[2*i +: 2]      = s;
        req_op[3*i +: 3]      = 3'd5;
        req_din[16*i +: 16]   = d;
        req_addr[25*i +: 25]  = a;
    endtask

    initial begin
        int exp_order [5];
        int n_dack;
        exp_order = '{0, 1, 2, 3, 0};

        reset     = 1'b0;
        req_valid = '0;
        req_cmd   = '0;
        req_sz    = '0;
        req_op    = '0;
        req_din   = '0;
        req_addr  = '0;
        fetching  = 1'b0;
`ifdef DDR2_ARB_STATS_EN
        stat_sel  = 3'd0;
`endif
        tick();
        tick();
        check("rst_cmd",  32'(cmd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack",  32'(req_ack), 32'd0);
        check("rst_gid",  32'(grant_id), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        reset = 1'b1;
        tick();

        // Round robin: all four SRD, grant order 0,1,2,3 then wrap to 0.
        fetching = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 3'd1, 2'd0, 16'h0, 25'(32'h100 + i));
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_gid",  32'(grant_id), 32'(exp_order[k]));
            check("rr_cmd",  32'(cmd), 32'd1);
            check("rr_addr", 32'(addr), 32'(32'h100 + exp_order[k]));
            tick();
            check("rr_ack",  32'(req_ack), 32'(1 << exp_order[k]));
        end
        req_valid = '0;
        tick();
        check("rr_idle", 32'(busy), 32'd0);

        // Single SWR from requester 0.
        set_req(0, 1'b1, 3'd2, 2'd1, 16'hBEEF, 25'h1ABCDE);
        tick();
        check("swr_cmd",  32'(cmd), 32'd2);
        check("swr_addr", 32'(addr), 32'h1ABCDE);
        check("swr_din",  32'(din), 32'hBEEF);
        check("swr_sz",   32'(sz), 32'd1);
        check("swr_op",   32'(op), 32'd5);
        check("swr_busy", 32'(busy), 32'd1);
        check("swr_noack", 32'(req_ack), 32'd0);
        tick();
        check("swr_ack",  32'(req_ack), 32'b0001);
        check("swr_cmd0", 32'(cmd), 32'd0);
        check("swr_err",  32'(req_err), 32'd0);
        req_valid = '0;
        tick();
        check("swr_oneack", 32'(req_ack), 32'd0);

        // Illegal command 7 from requester 1 is dropped with an error pulse.
        set_req(1, 1'b1, 3'd7, 2'd0, 16'h0, 25'h0);
        tick();
        check("drop_ack",  32'(req_ack), 32'b0010);
        check("drop_err",  32'(req_err), 32'b0010);
        check("drop_cmd",  32'(cmd), 32'd0);
        check("drop_busy", 32'(busy), 32'd0);
        req_valid = '0;
        tick();
        check("drop_once", 32'(req_ack | req_err), 32'd0);
`ifdef DDR2_ARB_STATS_EN
        stat_sel = 3'd1;
        #1;
        check("stat_drops1",  32'(stat_drops), 32'd1);
        check("stat_grants1", 32'(stat_grants), 32'd1);
        stat_sel = 3'd0;
        #1;
        check("stat_grants0", 32'(stat_grants), 32'd3);
`endif

        // ISSUE held for 10 cycles without fetching.
        fetching = 1'b0;
        set_req(3, 1'b1, 3'd1, 2'd2, 16'h1234, 25'h0F0F0F);
        tick();
        check("hold_gid", 32'(grant_id), 32'd3);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold_cmd",  32'(cmd), 32'd1);
            check("hold_addr", 32'(addr), 32'h0F0F0F);
            check("hold_ack",  32'(req_ack), 32'd0);
        end
        fetching = 1'b1;
        tick();
        check("hold_release_ack", 32'(req_ack), 32'b1000);
        req_valid = '0;

        // BWR sz=1 from requester 2: four beats, stalled mid-burst.
        n_dack = 0;
        set_req(2, 1'b1, 3'd4, 2'd1, 16'hD000, 25'h0A5A5);
        tick();
        check("bwr_cmd", 32'(cmd), 32'd4);
        check("bwr_din0", 32'(din), 32'hD000);
        check("bwr_gid", 32'(grant_id), 32'd2);
        tick();
        check("bwr_ack", 32'(req_ack), 32'b0100);
        check("bwr_dack1", 32'(req_data_ack), 32'b0100);
        if (req_data_ack[2]) n_dack++;
        req_valid = '0;
        req_din[32 +: 16] = 16'hD001;
        tick();
        check("bwr_din1", 32'(din), 32'hD001);
        fetching = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bwr_stall_din",  32'(din), 32'hD001);
            check("bwr_stall_dack", 32'(req_data_ack), 32'd0);
            check("bwr_stall_busy", 32'(busy), 32'd1);
        end
        fetching = 1'b1;
        tick();
        check("bwr_dack2", 32'(req_data_ack), 32'b0100);
        if (req_data_ack[2]) n_dack++;
        req_din[32 +: 16] = 16'hD002;
        tick();
        check("bwr_din2", 32'(din), 32'hD002);
        tick();
        check("bwr_dack3", 32'(req_data_ack), 32'b0100);
        if (req_data_ack[2]) n_dack++;
        req_din[32 +: 16] = 16'hD003;
        tick();
        check("bwr_din3", 32'(din), 32'hD003);
        check("bwr_busy3", 32'(busy), 32'd1);
        tick();
        check("bwr_dack4", 32'(req_data_ack), 32'b0100);
        if (req_data_ack[2]) n_dack++;
        check("bwr_done_busy", 32'(busy), 32'd0);
        tick();
        check("bwr_no_extra", 32'(req_data_ack), 32'd0);
        check("bwr_beats", 32'(n_dack), 32'd4);

        // Reset in the middle of an 8-beat burst from requester 1.
        set_req(1, 1'b1, 3'd4, 2'd3, 16'hA5A5, 25'h1FFFFFF);
        tick();
        check("rb_gid", 32'(grant_id), 32'd1);
        tick();
        check("rb_ack", 32'(req_ack), 32'b0010);
        req_valid = '0;
        tick();
        check("rb_burst", 32'(busy), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check("rb_cmd",  32'(cmd), 32'd0);
        check("rb_din",  32'(din), 32'd0);
        check("rb_addr", 32'(addr), 32'd0);
        check("rb_sz",   32'(sz), 32'd0);
        check("rb_busy", 32'(busy), 32'd0);
        check("rb_gid0", 32'(grant_id), 32'd0);
        check("rb_acks", 32'(req_ack | req_data_ack | req_err), 32'd0);
        #2;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rb_quiet", 32'({busy, req_ack, req_data_ack}), 32'd0);
        end
`ifdef DDR2_ARB_STATS_EN
        check("rb_stat_clr", 32'(stat_grants), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
